carpark_monitor: RTL and testbench

CARPARK_MONITOR -- requirements
Module: carpark_monitor

---
 rtl/carpark_pkg.sv | 18 +
 rtl/sensor_decoder.sv | 83 ++++++++
 rtl/carpark_monitor.sv | 53 +++++
 tb/tb_carpark_monitor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/carpark_pkg.sv
// Shared definitions for the car park occupancy monitor: decoder states and default sizing.
package carpark_pkg;

  localparam int unsigned MAX_CARS_DEF = 15;
  localparam int unsigned CW_DEF       = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN1   = 3'd1,
    EN2   = 3'd2,
    EN3   = 3'd3,
    EX1   = 3'd4,
    EX2   = 3'd5,
    EX3   = 3'd6,
    WAIT0 = 3'd7
  } state_t;

endpackage

// File: rtl/sensor_decoder.sv
// Registers the two gate beams and decodes complete entry/exit passes into one-cycle pulses.
module sensor_decoder
  import carpark_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic enter_c,
  output logic exit_c,
  output logic car_enter,
  output logic car_exit
);

  logic       a_q;
  logic       b_q;
  logic [1:0] ab;
  state_t     state;

  assign ab = {a_q, b_q};

  // Completion is visible one edge early so the counter can update alongside the pulse.
  assign enter_c = (state == EN3) && (ab == 2'b00);
  assign exit_c  = (state == EX3) && (ab == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      state     <= IDLE;
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
    end else begin
      a_q       <= a;
      b_q       <= b;
      car_enter <= enter_c;
      car_exit  <= exit_c;
      case (state)
        IDLE: begin
          case (ab)
            2'b10:   state <= EN1;
            2'b01:   state <= EX1;
            2'b11:   state <= WAIT0;
            default: state <= IDLE;
          endcase
        end
        EN1: begin
          if (ab == 2'b11)      state <= EN2;
          else if (ab == 2'b00) state <= IDLE;
          else if (ab != 2'b10) state <= WAIT0;
        end
        EN2: begin
          if (ab == 2'b01)      state <= EN3;
          else if (ab == 2'b00) state <= IDLE;
          else if (ab != 2'b11) state <= WAIT0;
        end
        EN3: begin
          if (ab == 2'b00)      state <= IDLE;
          else if (ab != 2'b01) state <= WAIT0;
        end
        EX1: begin
          if (ab == 2'b11)      state <= EX2;
          else if (ab == 2'b00) state <= IDLE;
          else if (ab != 2'b01) state <= WAIT0;
        end
        EX2: begin
          if (ab == 2'b10)      state <= EX3;
          else if (ab == 2'b00) state <= IDLE;
          else if (ab != 2'b11) state <= WAIT0;
        end
        EX3: begin
          if (ab == 2'b00)      state <= IDLE;
          else if (ab != 2'b10) state <= WAIT0;
        end
        WAIT0: begin
          if (ab == 2'b00) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/carpark_monitor.sv
// Car park occupancy monitor: gate decoder plus saturating occupancy counter and status flags.
module carpark_monitor
  import carpark_pkg::*;
#(
  parameter int unsigned MAX_CARS = MAX_CARS_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          b,
  output logic          car_enter,
  output logic          car_exit,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CARS);

  logic enter_c;
  logic exit_c;

  sensor_decoder u_dec (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .enter_c   (enter_c),
    .exit_c    (exit_c),
    .car_enter (car_enter),
    .car_exit  (car_exit)
  );

  // Saturating occupancy; an attempted overflow/underflow latches err until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else if (enter_c) begin
      if (count == MAX_CNT) err   <= 1'b1;
      else                  count <= count + CW'(1);
    end else if (exit_c) begin
      if (count == '0) err   <= 1'b1;
      else             count <= count - CW'(1);
    end
  end

  assign full  = (count == MAX_CNT);
  assign empty = (count == '0);

endmodule

// File: tb/tb_carpark_monitor.sv
// Directed bench for carpark_monitor: gate sequences with hand-computed occupancy and pulse counts.
module tb_carpark_monitor;
  import carpark_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic       b;
  logic       car_enter;
  logic       car_exit;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       err;

  int tests  = 0;
  int failed = 0;
  int n_enter = 0;
  int n_exit  = 0;
  int n_both  = 0;

  carpark_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .car_enter (car_enter),
    .car_exit  (car_exit),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (car_enter) n_enter++;
    if (car_exit)  n_exit++;
    if (car_enter && car_exit) n_both++;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold a sensor pattern for n cycles, starting and ending on a falling edge.
  task automatic drive(input logic [1:0] ab, input int n);
    a = ab[1];
    b = ab[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic do_entry();
    drive(2'b00, 2); drive(2'b10, 2); drive(2'b11, 2); drive(2'b01, 2); drive(2'b00, 4);
  endtask

  task automatic do_exit();
    drive(2'b00, 2); drive(2'b01, 2); drive(2'b11, 2); drive(2'b10, 2); drive(2'b00, 4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a = 1'b0;
    b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int e0, x0;

  initial begin
    rst = 1'b1;
    a = 1'b0;
    b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full), 0);
    check("rst_err",   int'(err), 0);
    check("rst_enter", int'(car_enter), 0);
    check("rst_exit",  int'(car_exit), 0);
    check("rst_state", int'(dut.u_dec.state), int'(IDLE));
    rst = 1'b0;
    drive(2'b00, 2);
    check("post_rst_enter", n_enter, 0);

    // First entry with exact latency: 00 applied before edge N, pulse after N+1.
    drive(2'b10, 2); drive(2'b11, 2); drive(2'b01, 2);
    a = 1'b0; b = 1'b0;
    @(posedge clk); #1;
    check("lat_n_enter", int'(car_enter), 0);
    check("lat_n_count", int'(count), 0);
    @(posedge clk); #1;
    check("lat_n1_enter", int'(car_enter), 1);
    check("lat_n1_count", int'(count), 1);
    @(posedge clk); #1;
    check("lat_n2_enter", int'(car_enter), 0);
    @(negedge clk);
    drive(2'b00, 2);
    for (int i = 0; i < 4; i++) do_entry();
    check("five_enter_pulses", n_enter, 5);
    check("five_count", int'(count), 5);
    check("five_err", int'(err), 0);
    check("five_empty", int'(empty), 0);

    for (int i = 0; i < 4; i++) do_exit();
    check("exits_count", int'(count), 1);
    check("exits_pulses", n_exit, 4);
    for (int i = 0; i < 5; i++) do_entry();
    check("reenter_count", int'(count), 6);
    check("reenter_pulses", n_enter, 10);

    for (int i = 1; i <= 15; i++) begin
      do_entry();
      check($sformatf("sat_count_%0d", i), int'(count), (6 + i > 15) ? 15 : 6 + i);
      check($sformatf("sat_err_%0d", i), int'(err), (i >= 10) ? 1 : 0);
      if (i == 8) check("not_full_8", int'(full), 0);
      if (i == 9) check("full_9", int'(full), 1);
    end
    check("sat_pulses", n_enter, 25);

    // Aborted and illegal patterns produce no pulses and return to IDLE.
    e0 = n_enter; x0 = n_exit;
    drive(2'b10, 2); drive(2'b00, 3);
    check("abort_en_state", int'(dut.u_dec.state), int'(IDLE));
    drive(2'b01, 2); drive(2'b10, 2); drive(2'b00, 3);
    check("illegal_state", int'(dut.u_dec.state), int'(IDLE));
    drive(2'b11, 2); drive(2'b00, 3);
    check("both_state", int'(dut.u_dec.state), int'(IDLE));
    check("abort_enter", n_enter - e0, 0);
    check("abort_exit", n_exit - x0, 0);
    check("abort_count", int'(count), 15);

    // Underflow from empty; err stays set while counting continues.
    do_reset();
    x0 = n_exit;
    do_exit();
    check("uf_pulse", n_exit - x0, 1);
    check("uf_count", int'(count), 0);
    check("uf_empty", int'(empty), 1);
    check("uf_err", int'(err), 1);
    do_entry();
    check("sticky_count", int'(count), 1);
    check("sticky_err", int'(err), 1);

    // Reset while in EN3 discards the partial pass.
    do_reset();
    drive(2'b10, 2); drive(2'b11, 2); drive(2'b01, 2);
    check("en3_state", int'(dut.u_dec.state), int'(EN3));
    e0 = n_enter;
    rst = 1'b1;
    @(negedge clk);
    a = 1'b0; b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 4);
    check("midrst_enter", n_enter - e0, 0);
    check("midrst_count", int'(count), 0);
    check("midrst_err", int'(err), 0);
    do_entry();
    check("midrst_after", int'(count), 1);

    check("mutex", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
